// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns the M-stage load/store access into a single outstanding
// request/handshake bus transaction. Optional kseg0/kseg1 mapping under DMEM_BRIDGE_ADDR_MAP_EN.
module dmem_bridge (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        exc_flush,
  input  logic        stall_others,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        cancel_q, cancel_d;

  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic        start;
  logic        kill;

  // Decode transfer size from the byte enables; loads always fetch the aligned word.
  always_comb begin
    case (mem_wen)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: req_size = 2'd0;
      4'b0011, 4'b1100:                   req_size = 2'd1;
      default:                            req_size = 2'd2;
    endcase
    req_addr = (mem_wen == 4'b0000) ? {mem_addr[31:2], 2'b00} : mem_addr;
  end

  assign start = (state_q == S_IDLE) && mem_en && !exc_flush;
  // A flush arriving in the same cycle as data_ok must still cancel the capture.
  assign kill  = cancel_q || exc_flush;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cancel_d  = cancel_q;
    data_req  = 1'b0;
    mem_stall = 1'b0;

    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (start) begin
          wr_d      = |mem_wen;
          size_d    = req_size;
          addr_d    = req_addr;
          wdata_d   = mem_wdata;
          mem_stall = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        data_req  = 1'b1;
        mem_stall = 1'b1;
        if (exc_flush)    cancel_d = 1'b1;
        if (data_addr_ok) state_d  = S_WAIT;
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (exc_flush) cancel_d = 1'b1;
        if (data_data_ok) begin
          if (kill) begin
            cancel_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            if (!wr_q) rdata_d = data_rdata;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!stall_others) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      cancel_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_wdata = wdata_q;
  assign mem_rdata  = rdata_q;

`ifdef DMEM_BRIDGE_ADDR_MAP_EN
  assign data_addr = (addr_q[31:30] == 2'b10) ? (addr_q & 32'h1FFF_FFFF) : addr_q;
`else
  assign data_addr = addr_q;
`endif

endmodule
